// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with show-ahead output, edge or level strobes,
// simultaneous push/pop, fill-level/almost flags and sticky overflow/underflow flags.
module fifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH_LOG2    = 2,
    parameter bit EDGE_TRIG     = 1'b1,
    parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [WIDTH-1:0]      i_dat,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_clr_err,
    output logic [WIDTH-1:0]      o_dat,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Pointer width stays at least 1 bit so a single-entry FIFO still elaborates.
    localparam int PW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam logic [PW-1:0]         PTR_LAST = PW'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]    mem [0:DEPTH-1];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DEPTH_LOG2:0] level;
    logic                push_q;
    logic                pop_q;
    logic                overflow;
    logic                underflow;

    logic push_eff;
    logic pop_eff;
    logic push_ok;
    logic pop_ok;

    // Handshake: a strobe is an operation request; it is accepted (push_ok/pop_ok)
    // when space/data exists, otherwise it is dropped and the sticky error flag set.
    always_comb begin
        push_eff = EDGE_TRIG ? (i_push & ~push_q) : i_push;
        pop_eff  = EDGE_TRIG ? (i_pop & ~pop_q) : i_pop;
        pop_ok   = pop_eff & (level != '0);
        push_ok  = push_eff & ((level != LVL_FULL) | pop_ok);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            push_q <= i_push;
            pop_q  <= i_pop;
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LVL_ONE;
            end else if (pop_ok && !push_ok) begin
                level <= level - LVL_ONE;
            end
            // A new error event in the same cycle takes priority over the clear.
            overflow  <= (push_eff & ~push_ok) | (overflow & ~i_clr_err);
            underflow <= (pop_eff & ~pop_ok) | (underflow & ~i_clr_err);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_dat;
        end
    end

    assign o_dat          = mem[rd_ptr];
    assign o_level        = level;
    assign o_empty        = (level == '0);
    assign o_full         = (level == LVL_FULL);
    assign o_almost_full  = (32'(level) >= AFULL_THRESH);
    assign o_almost_empty = (32'(level) <= AEMPTY_THRESH);
    assign o_overflow     = overflow;
    assign o_underflow    = underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: three configurations share a clock; one is active at a time
// and is compared every cycle against a queue-based model of the FIFO rules.
module tb_fifo_param;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        tb_push = 1'b0;
    logic        tb_pop = 1'b0;
    logic        tb_clr = 1'b0;
    logic [15:0] tb_dat = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    // ---- instance 0: defaults (W8, D4, edge strobes) ----
    logic [7:0] d0_dat;
    logic       d0_empty, d0_full, d0_af, d0_ae, d0_ovf, d0_udf;
    logic [2:0] d0_level;
    fifo_param u0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_dat(tb_dat[7:0]),
        .i_push(tb_push & (sel == 2'd0)), .i_pop(tb_pop & (sel == 2'd0)),
        .i_clr_err(tb_clr & (sel == 2'd0)),
        .o_dat(d0_dat), .o_empty(d0_empty), .o_full(d0_full), .o_level(d0_level),
        .o_almost_full(d0_af), .o_almost_empty(d0_ae),
        .o_overflow(d0_ovf), .o_underflow(d0_udf)
    );

    // ---- instance 1: W8, D4, level strobes ----
    logic [7:0] d1_dat;
    logic       d1_empty, d1_full, d1_af, d1_ae, d1_ovf, d1_udf;
    logic [2:0] d1_level;
    fifo_param #(.EDGE_TRIG(1'b0)) u1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_dat(tb_dat[7:0]),
        .i_push(tb_push & (sel == 2'd1)), .i_pop(tb_pop & (sel == 2'd1)),
        .i_clr_err(tb_clr & (sel == 2'd1)),
        .o_dat(d1_dat), .o_empty(d1_empty), .o_full(d1_full), .o_level(d1_level),
        .o_almost_full(d1_af), .o_almost_empty(d1_ae),
        .o_overflow(d1_ovf), .o_underflow(d1_udf)
    );

    // ---- instance 2: W16, D16, thresholds 12/3, edge strobes ----
    logic [15:0] d2_dat;
    logic        d2_empty, d2_full, d2_af, d2_ae, d2_ovf, d2_udf;
    logic [4:0]  d2_level;
    fifo_param #(.WIDTH(16), .DEPTH_LOG2(4), .AFULL_THRESH(12), .AEMPTY_THRESH(3)) u2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_dat(tb_dat),
        .i_push(tb_push & (sel == 2'd2)), .i_pop(tb_pop & (sel == 2'd2)),
        .i_clr_err(tb_clr & (sel == 2'd2)),
        .o_dat(d2_dat), .o_empty(d2_empty), .o_full(d2_full), .o_level(d2_level),
        .o_almost_full(d2_af), .o_almost_empty(d2_ae),
        .o_overflow(d2_ovf), .o_underflow(d2_udf)
    );

    // Observed outputs of the active instance, widened to common sizes.
    logic [15:0] obs_dat;
    logic [31:0] obs_level;
    logic        obs_empty, obs_full, obs_af, obs_ae, obs_ovf, obs_udf;
    always_comb begin
        obs_dat = '0; obs_level = '0; obs_empty = 1'b0; obs_full = 1'b0;
        obs_af = 1'b0; obs_ae = 1'b0; obs_ovf = 1'b0; obs_udf = 1'b0;
        case (sel)
            2'd0: begin
                obs_dat = {8'h00, d0_dat}; obs_level = 32'(d0_level); obs_empty = d0_empty;
                obs_full = d0_full; obs_af = d0_af; obs_ae = d0_ae; obs_ovf = d0_ovf; obs_udf = d0_udf;
            end
            2'd1: begin
                obs_dat = {8'h00, d1_dat}; obs_level = 32'(d1_level); obs_empty = d1_empty;
                obs_full = d1_full; obs_af = d1_af; obs_ae = d1_ae; obs_ovf = d1_ovf; obs_udf = d1_udf;
            end
            default: begin
                obs_dat = d2_dat; obs_level = 32'(d2_level); obs_empty = d2_empty;
                obs_full = d2_full; obs_af = d2_af; obs_ae = d2_ae; obs_ovf = d2_ovf; obs_udf = d2_udf;
            end
        endcase
    end

    // ---- reference model ----
    logic [15:0] exp_q[$];
    int          m_depth, m_af, m_ae;
    logic        m_edge;
    logic [15:0] m_mask;
    logic        m_pp, m_pq, m_ovf, m_udf;

    task automatic select_cfg(input logic [1:0] s);
        sel = s;
        case (s)
            2'd0: begin m_depth = 4;  m_edge = 1'b1; m_af = 3;  m_ae = 1; m_mask = 16'h00ff; end
            2'd1: begin m_depth = 4;  m_edge = 1'b0; m_af = 3;  m_ae = 1; m_mask = 16'h00ff; end
            default: begin m_depth = 16; m_edge = 1'b1; m_af = 12; m_ae = 3; m_mask = 16'hffff; end
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pp = 1'b0; m_pq = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic [15:0] d, input logic c);
        logic want_push, want_pop, pop_ok, push_ok;
        want_push = m_edge ? (p && !m_pp) : p;
        want_pop  = m_edge ? (q && !m_pq) : q;
        pop_ok  = want_pop && (exp_q.size() != 0);
        push_ok = want_push && ((exp_q.size() < m_depth) || pop_ok);
        if (pop_ok) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(d & m_mask);
        m_ovf = (want_push && !push_ok) || (m_ovf && !c);
        m_udf = (want_pop && !pop_ok) || (m_udf && !c);
        m_pp = p;
        m_pq = q;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int lvl;
        lvl = exp_q.size();
        check({tag, ".level"}, obs_level, 32'(lvl));
        check({tag, ".empty"}, 32'(obs_empty), 32'(lvl == 0));
        check({tag, ".full"}, 32'(obs_full), 32'(lvl == m_depth));
        check({tag, ".afull"}, 32'(obs_af), 32'(lvl >= m_af));
        check({tag, ".aempty"}, 32'(obs_ae), 32'(lvl <= m_ae));
        check({tag, ".ovf"}, 32'(obs_ovf), 32'(m_ovf));
        check({tag, ".udf"}, 32'(obs_udf), 32'(m_udf));
        if (lvl != 0) check({tag, ".dat"}, 32'(obs_dat), 32'(exp_q[0]));
    endtask

    // One clock cycle: drive after the falling edge, update model at the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input string tag, input logic p, input logic q, input logic [15:0] d,
                       input logic c);
        tb_push = p; tb_pop = q; tb_dat = d; tb_clr = c;
        @(posedge i_clk);
        if (!i_reset) model_step(p, q, d, c);
        @(negedge i_clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] s);
        tb_push = 1'b0; tb_pop = 1'b0; tb_clr = 1'b0;
        select_cfg(s);
        i_reset = 1'b1;
        model_reset();
        @(negedge i_clk);
        check_all("reset");
        i_reset = 1'b0;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 1'($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        // ---------- default configuration ----------
        do_reset(2'd0);
        cyc("push_a1", 1'b1, 1'b0, 16'h00a1, 1'b0); idle("gap");
        cyc("push_b2", 1'b1, 1'b0, 16'h00b2, 1'b0); idle("gap");
        cyc("push_c3", 1'b1, 1'b0, 16'h00c3, 1'b0); idle("gap");
        check("plan.afull_at3", 32'(obs_af), 32'd1);
        cyc("push_d4", 1'b1, 1'b0, 16'h00d4, 1'b0); idle("gap");
        check("plan.full_level", obs_level, 32'd4);
        check("plan.head_a1", 32'(obs_dat), 32'h00a1);
        cyc("push_ovf", 1'b1, 1'b0, 16'h00ee, 1'b0); idle("gap");
        check("plan.ovf_set", 32'(obs_ovf), 32'd1);
        cyc("clr_err", 1'b0, 1'b0, 16'h0000, 1'b1); idle("gap");
        for (int i = 0; i < 4; i++) begin
            cyc("drain", 1'b0, 1'b1, 16'h0000, 1'b0); idle("gap");
        end
        cyc("pop_udf", 1'b0, 1'b1, 16'h0000, 1'b0); idle("gap");
        check("plan.udf_set", 32'(obs_udf), 32'd1);
        cyc("clr_err", 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) cyc("hold_push", 1'b1, 1'b0, 16'h003c, 1'b0);
        idle("gap");
        check("plan.hold_one", obs_level, 32'd1);
        cyc("drain", 1'b0, 1'b1, 16'h0000, 1'b0); idle("gap");
        cyc("empty_pushpop", 1'b1, 1'b1, 16'h0042, 1'b0); idle("gap");
        cyc("drain", 1'b0, 1'b1, 16'h0000, 1'b0); idle("gap");
        for (int i = 0; i < 3; i++) begin
            cyc("fill3", 1'b1, 1'b0, 16'(8'h10 + i), 1'b0); idle("gap");
        end
        // Asynchronous reset in the middle of the low phase, checked before the next edge.
        #2 i_reset = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(negedge i_clk);
        i_reset = 1'b0;
        cyc("push_77", 1'b1, 1'b0, 16'h0077, 1'b0); idle("gap");
        check("plan.dat_77", 32'(obs_dat), 32'h0077);
        // Release with push already high: the first edge after release takes one push.
        i_reset = 1'b1; model_reset(); tb_push = 1'b1; tb_dat = 16'h0099;
        @(negedge i_clk);
        i_reset = 1'b0;
        cyc("release_push", 1'b1, 1'b0, 16'h0099, 1'b0);
        idle("gap");
        random_run(300);

        // ---------- level-strobe configuration ----------
        do_reset(2'd1);
        cyc("lvl_push", 1'b1, 1'b0, 16'h0011, 1'b0);
        cyc("lvl_push", 1'b1, 1'b0, 16'h0022, 1'b0);
        for (int i = 0; i < 6; i++) cyc("lvl_pushpop", 1'b1, 1'b1, 16'(8'h55 + i), 1'b0);
        check("plan.lvl_steady", obs_level, 32'd2);
        cyc("lvl_fill", 1'b1, 1'b0, 16'h00a0, 1'b0);
        cyc("lvl_fill", 1'b1, 1'b0, 16'h00a1, 1'b0);
        cyc("lvl_full_pushpop", 1'b1, 1'b1, 16'h00a2, 1'b0);
        check("plan.full_pushpop_ovf", 32'(obs_ovf), 32'd0);
        cyc("lvl_full_push", 1'b1, 1'b0, 16'h00a3, 1'b0);
        for (int i = 0; i < 5; i++) cyc("lvl_drain", 1'b0, 1'b1, 16'h0000, 1'b0);
        random_run(300);

        // ---------- wide/deep configuration ----------
        do_reset(2'd2);
        for (int i = 0; i < 16; i++) begin
            cyc("w_fill", 1'b1, 1'b0, 16'(16'h1000 + i * 16'h0101), 1'b0); idle("gap");
        end
        check("plan.w_full", 32'(obs_full), 32'd1);
        cyc("w_ovf", 1'b1, 1'b0, 16'hbeef, 1'b0); idle("gap");
        for (int i = 0; i < 16; i++) begin
            cyc("w_drain", 1'b0, 1'b1, 16'h0000, 1'b0); idle("gap");
        end
        random_run(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout got=running exp=finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the UART byte FIFO. It adds configurable data width and depth, a selectable strobe mode (edge-detected or level), simultaneous push/pop, fill-level and almost-full/almost-empty outputs, and sticky overflow/underflow error flags. It sits between the UART shift engines and the bus interface, and serves as the general buffering block for other peripherals.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH_LOG2, 2: log2 of depth; depth D = 2**DEPTH_LOG2 (≥1).
- EDGE_TRIG, 1: 1 = push/pop act on rising edge of strobe; 0 = act every cycle strobe is high.
- AFULL_THRESH, D-1: o_almost_full asserted when level ≥ this.
- AEMPTY_THRESH, 1: o_almost_empty asserted when level ≤ this.
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_dat  in  WIDTH  write data, sampled with accepted push.
- i_push  in  1  push strobe.
- i_pop  in  1  pop strobe.
- i_clr_err  in  1  synchronous clear of o_overflow/o_underflow.
- o_dat  out  WIDTH  head-of-queue word (show-ahead).
- o_empty  out  1  level == 0.
- o_full  out  1  level == D.
- o_level  out  DEPTH_LOG2+1  current word count, 0..D.
- o_almost_full  out  1  level ≥ AFULL_THRESH.
- o_almost_empty  out  1  level ≤ AEMPTY_THRESH.
- o_overflow  out  1  sticky: push rejected because full.
- o_underflow  out  1  sticky: pop rejected because empty.

## Operation
- Storage: D×WIDTH array; rd_ptr, wr_ptr DEPTH_LOG2 bits, wrap modulo D naturally; level counter DEPTH_LOG2+1 bits.
- Strobe qualification: EDGE_TRIG=1 → push_eff = i_push & ~push_q, pop_eff = i_pop & ~pop_q, with push_q/pop_q registered copies reset to 0; EDGE_TRIG=0 → push_eff = i_push, pop_eff = i_pop.
- pop_ok = pop_eff & (level != 0).
- push_ok = push_eff & (level != D | pop_ok); a push is accepted while full only if a pop is accepted in the same cycle.
- push_ok: mem[wr_ptr] ← i_dat, wr_ptr+1. pop_ok: rd_ptr+1.
- level: +1 on push_ok only, −1 on pop_ok only, unchanged if both or neither.
- Empty with push+pop in the same cycle: pop rejected (underflow set), push accepted, level becomes 1.
- Overflow: push_eff & ~push_ok → data dropped, o_overflow ← 1.
- Underflow: pop_eff & ~pop_ok → o_underflow ← 1.
- i_clr_err clears both flags; a set event in the same cycle wins over clear.
- o_dat = mem[rd_ptr], combinational from registered state. Undefined (don't care) while o_empty.
- Flags o_empty, o_full, o_almost_* decode combinationally from the level register. No glitch-free guarantee is needed beyond a register source.

## Timing
- Reset (async assert, takes effect immediately): pointers 0, level 0, push_q/pop_q 0, o_empty 1, o_full 0, o_level 0, o_almost_empty 1 (AEMPTY_THRESH≥0), o_almost_full 0 (AFULL_THRESH≥1), o_overflow 0, o_underflow 0. Memory contents are not reset.
- Reset mid-operation: all queued data is discarded; the queue state returns to empty immediately.
- Release is synchronous-safe: the first active edge after deassert evaluates strobes. With EDGE_TRIG=1 and i_push already high at release, one push is accepted on that first edge.
- Push latency: word accepted at edge N is visible on o_dat (if it was empty) and counted in o_level/o_empty after edge N, i.e. in cycle N+1.
- Pop latency: o_dat shows the next word in the cycle after the accepting edge.
- EDGE_TRIG=1: a strobe held high for k cycles yields exactly one operation. EDGE_TRIG=0: k operations.
- Throughput: one push and one pop per cycle (EDGE_TRIG=0).

## Test plan
- Defaults (W=8, D=4, EDGE_TRIG=1): reset, push 0xA1,0xB2,0xC3,0xD4 as 1-cycle pulses with idle gaps → o_full=1, o_level=4, o_almost_full=1 from level 3, o_dat=0xA1; 4 pops return A1,B2,C3,D4 in order, o_empty=1.
- Full, push 0xEE → o_overflow=1, level stays 4, data unchanged. Then i_clr_err pulse → o_overflow=0. Empty, pop → o_underflow=1.
- EDGE_TRIG=0, level 2, push 0x55 and pop together for 6 cycles → level stays 2, output order preserved across pointer wrap. Full + simultaneous push/pop → both accepted, no overflow.
- EDGE_TRIG=1, i_push held high 5 cycles with i_dat=0x3C → exactly one word written, level=1. Empty + simultaneous push/pop → level=1, o_underflow=1.
- Reset asserted asynchronously mid-cycle at level 3 → o_empty=1, o_level=0, flags 0 before the next clock edge. Next push of 0x77 → o_dat=0x77.
- WIDTH=16, DEPTH_LOG2=4, AFULL_THRESH=12, AEMPTY_THRESH=3: fill 16 words → o_almost_empty drops at level 4, o_almost_full rises at level 12, o_full at 16; drain verifies all 16 words.
